// File: rtl/serial_rx_pkg.sv
// Shared frame layout for the serial frame receiver: field positions, the frame
// vector type and the frame acceptance check.
package serial_rx_pkg;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    localparam int START_IDX  = 0;
    localparam int DATA_LSB   = 1;
    localparam int DATA_MSB   = 8;
    localparam int PARITY_IDX = 9;
    localparam int STOP_IDX   = 10;

    typedef logic [FRAME_BITS-1:0] frame_t;

    // A frame is good with a low start bit, a high stop bit and odd parity over data+parity.
    function automatic logic frame_ok(input frame_t f);
        return (f[START_IDX] == 1'b0) && (f[STOP_IDX] == 1'b1) && (^f[PARITY_IDX:DATA_LSB]);
    endfunction

endpackage

// File: rtl/clk_debounce.sv
// Synchronizes the asynchronous serial bit clock, filters out pulses shorter than
// DEBOUNCE_LEN samples and emits a one-cycle pulse on each filtered falling edge.
module clk_debounce #(
    parameter int DEBOUNCE_LEN = 8
) (
    input  logic fclk,
    input  logic rst,
    input  logic clk_in,
    output logic fall
);

    logic       clk_meta;
    logic       clk_sync;
    logic       clk_filt;
    logic [7:0] cnt;

    always_ff @(posedge fclk) begin
        if (rst) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_filt <= 1'b1;
            cnt      <= 8'd0;
            fall     <= 1'b0;
        end else begin
            clk_meta <= clk_in;
            clk_sync <= clk_meta;
            fall     <= 1'b0;
            if (clk_sync != clk_filt) begin
                // The filtered level only follows once the new level has persisted long enough.
                if (cnt == 8'(DEBOUNCE_LEN - 1)) begin
                    clk_filt <= clk_sync;
                    cnt      <= 8'd0;
                    fall     <= ~clk_sync;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else begin
                cnt <= 8'd0;
            end
        end
    end

endmodule

// File: rtl/serial_frame_receiver.sv
// Keyboard-style 11-bit serial frame receiver with frame checking and held outputs.
// Optional partial-frame abort after TIMEOUT_CYCLES idle cycles: define RX_TIMEOUT_EN.
module serial_frame_receiver
    import serial_rx_pkg::*;
#(
    parameter int DEBOUNCE_LEN   = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 FCLK,
    input  logic                 RST,
    input  logic                 CLK,
    input  logic                 DATA,
    output logic [DATA_BITS-1:0] SCAN_CODE,
    output logic [DATA_BITS-1:0] DATA_OUTPUT_CHECK,
    output logic                 PARITY_CHECK_BIT,
    output logic                 DATA_VALID,
    output logic                 FRAME_DONE
);

    logic       data_meta;
    logic       data_sync;
    logic       bit_event;
    logic       timeout_hit;
    logic [3:0] bit_cnt;
    frame_t     shreg;
    frame_t     next_frame;
    logic       last_bit;

    clk_debounce #(
        .DEBOUNCE_LEN(DEBOUNCE_LEN)
    ) u_clk_debounce (
        .fclk   (FCLK),
        .rst    (RST),
        .clk_in (CLK),
        .fall   (bit_event)
    );

    always_ff @(posedge FCLK) begin
        if (RST) begin
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            data_meta <= DATA;
            data_sync <= data_meta;
        end
    end

    // First received bit ends up at bit 0 after all eleven shifts.
    assign next_frame = {data_sync, shreg[FRAME_BITS-1:1]};
    assign last_bit   = (bit_cnt == 4'(FRAME_BITS - 1));

`ifdef RX_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt;

    assign timeout_hit = (idle_cnt == IDLE_W'(TIMEOUT_CYCLES));

    always_ff @(posedge FCLK) begin
        if (RST || bit_event || timeout_hit || bit_cnt == 4'd0) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge FCLK) begin
        if (RST) begin
            bit_cnt           <= 4'd0;
            shreg             <= '0;
            SCAN_CODE         <= '0;
            DATA_OUTPUT_CHECK <= '0;
            PARITY_CHECK_BIT  <= 1'b0;
            DATA_VALID        <= 1'b0;
            FRAME_DONE        <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            if (bit_event) begin
                shreg <= next_frame;
                if (last_bit) begin
                    bit_cnt           <= 4'd0;
                    FRAME_DONE        <= 1'b1;
                    DATA_OUTPUT_CHECK <= next_frame[DATA_MSB:DATA_LSB];
                    PARITY_CHECK_BIT  <= next_frame[PARITY_IDX];
                    DATA_VALID        <= frame_ok(next_frame);
                    // A rejected frame leaves the last good scan code on display.
                    if (frame_ok(next_frame)) begin
                        SCAN_CODE <= next_frame[DATA_MSB:DATA_LSB];
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (timeout_hit) begin
                bit_cnt <= 4'd0;
                shreg   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed testbench for serial_frame_receiver; expectations for the idle-timeout
// scenario follow whether RX_TIMEOUT_EN is defined.
module tb_serial_frame_receiver;

    localparam int L = 8;
    localparam int P = 4 * L;

    logic       FCLK = 1'b0;
    logic       RST  = 1'b1;
    logic       CLK  = 1'b1;
    logic       DATA = 1'b1;
    logic [7:0] SCAN_CODE;
    logic [7:0] DATA_OUTPUT_CHECK;
    logic       PARITY_CHECK_BIT;
    logic       DATA_VALID;
    logic       FRAME_DONE;

    int checks     = 0;
    int failures   = 0;
    int done_count = 0;
    int done_before;

    serial_frame_receiver #(
        .DEBOUNCE_LEN   (L),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .FCLK              (FCLK),
        .RST               (RST),
        .CLK               (CLK),
        .DATA              (DATA),
        .SCAN_CODE         (SCAN_CODE),
        .DATA_OUTPUT_CHECK (DATA_OUTPUT_CHECK),
        .PARITY_CHECK_BIT  (PARITY_CHECK_BIT),
        .DATA_VALID        (DATA_VALID),
        .FRAME_DONE        (FRAME_DONE)
    );

    always #5 FCLK = ~FCLK;

    // Counts every cycle FRAME_DONE is high, so a stretched pulse shows up as extra completions.
    always @(negedge FCLK) begin
        if (FRAME_DONE) done_count++;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge FCLK);
    endtask

    task automatic sendBit(input logic b, input bit glitch);
        DATA = b;
        waitCycles(P);
        if (glitch) begin
            CLK = 1'b0;
            waitCycles(L - 2);
            CLK = 1'b1;
            waitCycles(P);
        end
        CLK = 1'b0;
        waitCycles(P);
        CLK = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic par, input logic stp, input bit glitch);
        sendBit(1'b0, glitch);
        for (int i = 0; i < 8; i++) sendBit(d[i], glitch);
        sendBit(par, glitch);
        sendBit(stp, glitch);
        waitCycles(P);
    endtask

    task automatic checkFrame(input string tag, input int done_exp, input int scan, input int raw,
                              input int par, input int valid);
        @(negedge FCLK);
        checkOutput({tag, ".frame_done"}, done_count - done_before, done_exp);
        checkOutput({tag, ".scan_code"}, SCAN_CODE, scan);
        checkOutput({tag, ".data_check"}, DATA_OUTPUT_CHECK, raw);
        checkOutput({tag, ".parity"}, PARITY_CHECK_BIT, par);
        checkOutput({tag, ".valid"}, DATA_VALID, valid);
    endtask

    initial begin
        waitCycles(5);
        done_before = done_count;
        checkFrame("reset", 0, 8'h00, 8'h00, 0, 0);
        RST = 1'b0;
        waitCycles(5);

        done_before = done_count;
        applyStimulus(8'h1C, 1'b0, 1'b1, 1'b0);
        checkFrame("valid_1c", 1, 8'h1C, 8'h1C, 0, 1);

        done_before = done_count;
        applyStimulus(8'hF0, 1'b0, 1'b1, 1'b0);
        checkFrame("bad_parity", 1, 8'h1C, 8'hF0, 0, 0);

        done_before = done_count;
        applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0);
        checkFrame("bad_stop", 1, 8'h1C, 8'h5A, 1, 0);

        done_before = done_count;
        applyStimulus(8'h5A, 1'b1, 1'b1, 1'b0);
        checkFrame("valid_5a", 1, 8'h5A, 8'h5A, 1, 1);

        done_before = done_count;
        applyStimulus(8'h1C, 1'b0, 1'b1, 1'b1);
        checkFrame("glitch", 1, 8'h1C, 8'h1C, 0, 1);

        // Partial frame then reset: outputs clear and the next frame must align from its start bit.
        done_before = done_count;
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        sendBit(1'b1, 1'b0);
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        @(posedge FCLK);
        RST = 1'b1;
        @(posedge FCLK);
        RST = 1'b0;
        checkFrame("mid_reset", 0, 8'h00, 8'h00, 0, 0);
        waitCycles(P);

        done_before = done_count;
        applyStimulus(8'h29, 1'b0, 1'b1, 1'b0);
        checkFrame("valid_29", 1, 8'h29, 8'h29, 0, 1);

        done_before = done_count;
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        sendBit(1'b0, 1'b0);
        sendBit(1'b1, 1'b0);
        waitCycles(300);
        applyStimulus(8'h1C, 1'b0, 1'b1, 1'b0);
`ifdef RX_TIMEOUT_EN
        checkFrame("timeout", 1, 8'h1C, 8'h1C, 0, 1);
`else
        checkFrame("no_timeout", 1, 8'h29, 8'hC5, 1, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
